// File: rtl/median_ctrl_pkg.sv
// Shared types and sizing helpers for the median-filter frame sequencer.
package median_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_FLUSH,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int RGB_W        = 24;
    localparam int FRAME_CNT_W  = 16;
    localparam int CLEAR_CYCLES = 2;

    // Pixels per frame.
    function automatic int frame_pixels(input int rows, input int cols);
        return rows * cols;
    endfunction

    // Width able to hold 0..N inclusive.
    function automatic int frame_cnt_w(input int rows, input int cols);
        return $clog2(rows * cols + 1);
    endfunction

endpackage

// File: rtl/median_ctrl_wdog.sv
// FLUSH watchdog: counts enabled cycles without a pipeline output and
// flags expiry on the WDOG_CYCLES-th consecutive idle cycle.
module median_ctrl_wdog #(
    parameter int WDOG_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int W = $clog2(WDOG_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(WDOG_CYCLES - 1);

    logic [W-1:0] cnt;

    // Idle-cycle counter; any output or leaving FLUSH restarts it.
    always_ff @(posedge clk) begin
        if (rst || !en || clr) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = en && !clr && (cnt == LAST);

endmodule

// File: rtl/median_frame_ctrl.sv
// Frame sequencer for the grayscale median pipeline: feeds one frame,
// flushes with zero pixels, gates exactly ROWS*COLS outputs, resets the
// pipeline between frames. Define MEDIAN_CTRL_WDOG_EN for the FLUSH
// watchdog and ERR state.
module median_frame_ctrl
    import median_ctrl_pkg::*;
#(
    parameter int ROWS        = 360,
    parameter int COLS        = 480,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic                   pix_valid_i,
    output logic                   pix_ready_o,
    input  logic [RGB_W-1:0]       pix_rgb_i,
    output logic                   pipe_rst_o,
    output logic                   pipe_done_o,
    output logic [RGB_W-1:0]       pipe_rgb_o,
    input  logic                   med_done_i,
    input  logic [RGB_W-1:0]       med_rgb_i,
    output logic                   out_valid_o,
    output logic [RGB_W-1:0]       out_rgb_o,
    output logic                   out_last_o,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic                   err_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

    localparam int N     = frame_pixels(ROWS, COLS);
    localparam int CNT_W = frame_cnt_w(ROWS, COLS);
    localparam logic [CNT_W-1:0] N_C  = CNT_W'(N);
    localparam logic [CNT_W-1:0] N_M1 = CNT_W'(N - 1);

    state_t                 state, state_nxt;
    logic                   clr_cnt;
    logic [CNT_W-1:0]       in_cnt, out_cnt;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic                   hs, gate, flush_stb, abort_act, wdog_expire;

    assign pix_ready_o  = (state == ST_FEED);
    assign hs           = pix_valid_i && pix_ready_o && !abort_i;
    assign abort_act    = abort_i && (state != ST_IDLE);
    assign gate         = med_done_i && (out_cnt != N_C) && !abort_i &&
                          ((state == ST_FEED) || (state == ST_FLUSH));
    assign flush_stb    = (state == ST_FLUSH) && (out_cnt != N_C) && !abort_i;
    assign busy_o       = (state != ST_IDLE);
    assign frame_done_o = (state == ST_DONE) && !abort_i;
    assign frame_cnt_o  = frame_cnt;
    assign pipe_rst_o   = rst || abort_act || (state == ST_CLEAR) ||
                          (state == ST_DONE) || (state == ST_ERR);

`ifdef MEDIAN_CTRL_WDOG_EN
    logic err_q;

    median_ctrl_wdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .en     (state == ST_FLUSH),
        .clr    (med_done_i),
        .expire (wdog_expire)
    );

    // Sticky error: set on watchdog expiry, cleared by an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_nxt == ST_ERR) begin
            err_q <= 1'b1;
        end else if (start_i && !abort_i &&
                     ((state == ST_IDLE) || (state == ST_ERR))) begin
            err_q <= 1'b0;
        end
    end

    assign err_o = err_q;
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG_CYCLES == 0);
    assign wdog_expire = 1'b0;
    assign err_o       = 1'b0;
`endif

    // Next-state: abort beats everything, start only honoured in IDLE/ERR.
    always_comb begin
        state_nxt = state;
        if (abort_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start_i) state_nxt = ST_CLEAR;
                ST_CLEAR: if (clr_cnt == 1'(CLEAR_CYCLES - 1)) state_nxt = ST_FEED;
                ST_FEED:  if (hs && (in_cnt == N_M1))
                              state_nxt = (out_cnt == N_C) ? ST_DONE : ST_FLUSH;
                ST_FLUSH: if (out_cnt == N_C) state_nxt = ST_DONE;
                          else if (wdog_expire) state_nxt = ST_ERR;
                ST_DONE:  state_nxt = ST_IDLE;
                ST_ERR:   if (start_i) state_nxt = ST_CLEAR;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, counters and the registered pipeline/sink-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            clr_cnt     <= 1'b0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            frame_cnt   <= '0;
            pipe_done_o <= 1'b0;
            pipe_rgb_o  <= '0;
            out_valid_o <= 1'b0;
            out_rgb_o   <= '0;
            out_last_o  <= 1'b0;
        end else begin
            state       <= state_nxt;
            pipe_done_o <= hs || flush_stb;
            pipe_rgb_o  <= hs ? pix_rgb_i : '0;
            out_valid_o <= gate;
            out_rgb_o   <= gate ? med_rgb_i : '0;
            out_last_o  <= gate && (out_cnt == N_M1);
            clr_cnt     <= (state == ST_CLEAR) ? clr_cnt + 1'b1 : 1'b0;

            if (hs && (in_cnt != N_C)) in_cnt <= in_cnt + 1'b1;
            if (gate) out_cnt <= out_cnt + 1'b1;
            if (frame_done_o) frame_cnt <= frame_cnt + 1'b1;

            // Abort or a fresh frame start wipes the per-frame counters.
            if (abort_act || ((state_nxt == ST_CLEAR) && (state != ST_CLEAR))) begin
                in_cnt  <= '0;
                out_cnt <= '0;
                clr_cnt <= 1'b0;
            end
        end
    end

endmodule
